// File: rtl/branch_unit.sv
// Branch/jump resolution unit: compares rs/rt, resolves branches, jumps, calls and returns,
// and holds the result in an output register behind a valid/ready handshake.
module branch_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 6,
   parameter int RAS_DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [5:0]               opcode,
   input  logic [15:0]              imm,
   input  logic [DATA_WIDTH-1:0]    rs,
   input  logic [DATA_WIDTH-1:0]    rt,
   input  logic [ADDRESS_WIDTH:0]   pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDRESS_WIDTH:0]   next_pc,
   output logic                     taken,
   output logic [ADDRESS_WIDTH:0]   link_pc,
   output logic                     ras_err
);

   localparam int W  = ADDRESS_WIDTH + 1;
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
   localparam logic [W-1:0]  PC_ONE   = W'(1'b1);

   localparam logic [5:0] OP_BEQ  = 6'b001000;
   localparam logic [5:0] OP_BNE  = 6'b001001;
   localparam logic [5:0] OP_BGT  = 6'b001010;
   localparam logic [5:0] OP_BGTE = 6'b001011;
   localparam logic [5:0] OP_BLT  = 6'b001100;
   localparam logic [5:0] OP_BLTE = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b001110;
   localparam logic [5:0] OP_JAL  = 6'b001111;
   localparam logic [5:0] OP_JR   = 6'b010000;
   localparam logic [5:0] OP_RET  = 6'b010001;

   logic [W-1:0]  ras_q [RAS_DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  next_pc_q, next_pc_d;
   logic          taken_q, taken_d;
   logic [W-1:0]  link_pc_q, link_pc_d;
   logic          ras_err_q, ras_err_d;

   logic          in_ready_s, accept_s;
   logic          eq_s, gt_s, lt_s;
   logic [W-1:0]  fall_s, offset_s, br_pc_s, top_s;
   logic [W-1:0]  res_pc_s, res_link_s;
   logic          res_taken_s, res_err_s, push_s, pop_s, ras_empty_s;

   assign in_ready_s  = !flush && (!out_valid_q || out_ready);
   assign accept_s    = in_valid && in_ready_s;

   assign eq_s        = (rs == rt);
   assign gt_s        = ($signed(rs) > $signed(rt));
   assign lt_s        = ($signed(rs) < $signed(rt));

   assign fall_s      = pc + PC_ONE;
   assign offset_s    = W'($signed(imm));
   assign br_pc_s     = pc + offset_s;
   assign ras_empty_s = (cnt_q == {CW{1'b0}});
   // The stack top is the entry just below the write pointer.
   assign top_s       = ras_q[wp_q - PTR_ONE];

   // Decode the request into its result and stack action.
   always_comb begin
      res_pc_s    = fall_s;
      res_taken_s = 1'b0;
      res_link_s  = {W{1'b0}};
      res_err_s   = 1'b0;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      case (opcode)
         OP_BEQ:  res_taken_s = eq_s;
         OP_BNE:  res_taken_s = !eq_s;
         OP_BGT:  res_taken_s = gt_s;
         OP_BGTE: res_taken_s = !lt_s;
         OP_BLT:  res_taken_s = lt_s;
         OP_BLTE: res_taken_s = !gt_s;
         OP_J: begin
            res_pc_s    = W'(imm);
            res_taken_s = 1'b1;
         end
         OP_JAL: begin
            res_pc_s    = W'(imm);
            res_taken_s = 1'b1;
            res_link_s  = fall_s;
            push_s      = 1'b1;
         end
         OP_JR: begin
            res_pc_s    = W'(rs);
            res_taken_s = 1'b1;
         end
         OP_RET: begin
            res_taken_s = 1'b1;
            if (ras_empty_s) begin
               res_pc_s  = W'(rs);
               res_err_s = 1'b1;
            end else begin
               res_pc_s  = top_s;
               pop_s     = 1'b1;
            end
         end
         default: res_taken_s = 1'b0;
      endcase
      // Conditional branches only redirect to the offset target when taken.
      if ((opcode >= OP_BEQ) && (opcode <= OP_BLTE) && res_taken_s) begin
         res_pc_s = br_pc_s;
      end else begin
         res_pc_s = res_pc_s;
      end
   end

   // Next state of the output register and stack pointers.
   always_comb begin
      out_valid_d = out_valid_q;
      next_pc_d   = next_pc_q;
      taken_d     = taken_q;
      link_pc_d   = link_pc_q;
      ras_err_d   = ras_err_q;
      wp_d        = wp_q;
      cnt_d       = cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
         wp_d        = {PW{1'b0}};
         cnt_d       = {CW{1'b0}};
      end else if (accept_s) begin
         out_valid_d = 1'b1;
         next_pc_d   = res_pc_s;
         taken_d     = res_taken_s;
         link_pc_d   = res_link_s;
         ras_err_d   = res_err_s;
         if (push_s) begin
            wp_d  = wp_q + PTR_ONE;
            cnt_d = (cnt_q == CNT_FULL) ? cnt_q : (cnt_q + CNT_ONE);
         end else if (pop_s) begin
            wp_d  = wp_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            wp_d  = wp_q;
            cnt_d = cnt_q;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register and stack pointer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         next_pc_q   <= {W{1'b0}};
         taken_q     <= 1'b0;
         link_pc_q   <= {W{1'b0}};
         ras_err_q   <= 1'b0;
         wp_q        <= {PW{1'b0}};
         cnt_q       <= {CW{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         next_pc_q   <= next_pc_d;
         taken_q     <= taken_d;
         link_pc_q   <= link_pc_d;
         ras_err_q   <= ras_err_d;
         wp_q        <= wp_d;
         cnt_q       <= cnt_d;
      end
   end

   // Stack storage; a push when full lands on the oldest entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= {W{1'b0}};
         end
      end else if (accept_s && push_s) begin
         ras_q[wp_q] <= fall_s;
      end else begin
         ras_q[wp_q] <= ras_q[wp_q];
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign next_pc   = next_pc_q;
   assign taken     = taken_q;
   assign link_pc   = link_pc_q;
   assign ras_err   = ras_err_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, call/return and handshake
// sequences, then random requests compared against a queue-based reference model.
module tb_branch_unit;

   localparam logic [5:0] OP_BEQ  = 6'd8;
   localparam logic [5:0] OP_BNE  = 6'd9;
   localparam logic [5:0] OP_BGT  = 6'd10;
   localparam logic [5:0] OP_BGTE = 6'd11;
   localparam logic [5:0] OP_BLT  = 6'd12;
   localparam logic [5:0] OP_BLTE = 6'd13;
   localparam logic [5:0] OP_J    = 6'd14;
   localparam logic [5:0] OP_JAL  = 6'd15;
   localparam logic [5:0] OP_JR   = 6'd16;
   localparam logic [5:0] OP_RET  = 6'd17;

   logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, taken, ras_err;
   logic [5:0]  opcode;
   logic [15:0] imm;
   logic [31:0] rs, rt;
   logic [6:0]  pc, next_pc, link_pc;

   int checks = 0;
   int errors = 0;

   logic [6:0] ras_m[$];

   typedef struct {
      logic [5:0]  op;
      logic [15:0] im;
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  p;
      logic [6:0]  e_pc;
      logic        e_tk;
   } vec_t;

   vec_t vecs[13];

   branch_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .imm(imm), .rs(rs), .rt(rt), .pc(pc),
      .out_valid(out_valid), .out_ready(out_ready), .next_pc(next_pc), .taken(taken),
      .link_pc(link_pc), .ras_err(ras_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [5:0] op, input logic [15:0] im,
                       input logic [31:0] a, input logic [31:0] b, input logic [6:0] p);
      opcode = op; imm = im; rs = a; rt = b; pc = p;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic chk_res(input string nm, input logic [6:0] e_pc, input logic e_tk,
                          input logic [6:0] e_lk, input logic e_er);
      chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_pc"},    {25'd0, next_pc},   {25'd0, e_pc});
      chk({nm, "_taken"}, {31'd0, taken},     {31'd0, e_tk});
      chk({nm, "_link"},  {25'd0, link_pc},   {25'd0, e_lk});
      chk({nm, "_err"},   {31'd0, ras_err},   {31'd0, e_er});
   endtask

   // Reference model: PC arithmetic in plain integers, the stack as a bounded queue.
   task automatic model(input logic [5:0] op, input logic [15:0] im, input logic [31:0] a,
                        input logic [31:0] b, input logic [6:0] p,
                        output logic [6:0] e_pc, output logic e_tk,
                        output logic [6:0] e_lk, output logic e_er);
      int sa, sb, tgt;
      bit cond, is_br;
      sa = $signed(a);
      sb = $signed(b);
      tgt = int'(p) + int'($signed(im));
      e_pc = p + 7'd1; e_tk = 1'b0; e_lk = 7'd0; e_er = 1'b0;
      is_br = 1'b1;
      case (op)
         OP_BEQ:  cond = (sa == sb);
         OP_BNE:  cond = (sa != sb);
         OP_BGT:  cond = (sa > sb);
         OP_BGTE: cond = (sa >= sb);
         OP_BLT:  cond = (sa < sb);
         OP_BLTE: cond = (sa <= sb);
         default: begin cond = 1'b0; is_br = 1'b0; end
      endcase
      if (is_br) begin
         e_tk = cond;
         if (cond) e_pc = tgt[6:0];
      end else if (op == OP_J) begin
         e_pc = im[6:0]; e_tk = 1'b1;
      end else if (op == OP_JAL) begin
         e_pc = im[6:0]; e_tk = 1'b1; e_lk = p + 7'd1;
         ras_m.push_back(p + 7'd1);
         if (ras_m.size() > 4) void'(ras_m.pop_front());
      end else if (op == OP_JR) begin
         e_pc = a[6:0]; e_tk = 1'b1;
      end else if (op == OP_RET) begin
         e_tk = 1'b1;
         if (ras_m.size() > 0) e_pc = ras_m.pop_back();
         else begin e_pc = a[6:0]; e_er = 1'b1; end
      end
   endtask

   initial begin
      logic [6:0]  e_pc, e_lk;
      logic        e_tk, e_er;
      logic [5:0]  r_op;
      logic [15:0] r_im;
      logic [31:0] r_a, r_b;
      logic [6:0]  r_p;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = 6'd0; imm = 16'd0; rs = 32'd0; rt = 32'd0; pc = 7'd0;
      #2;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_pc",    {25'd0, next_pc},   32'd0);
      chk("rst_taken", {31'd0, taken},     32'd0);
      chk("rst_link",  {25'd0, link_pc},   32'd0);
      chk("rst_err",   {31'd0, ras_err},   32'd0);
      chk("rst_ready", {31'd0, in_ready},  32'd1);
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      vecs[0]  = '{OP_BEQ,  16'hFFFD, 32'd5,          32'd5,          7'd10,  7'd7,  1'b1};
      vecs[1]  = '{OP_BGT,  16'd4,    32'hFFFFFFFF,   32'd1,          7'd10,  7'd11, 1'b0};
      vecs[2]  = '{OP_BEQ,  16'd5,    32'd9,          32'd9,          7'd126, 7'd3,  1'b1};
      vecs[3]  = '{OP_BLT,  16'd8,    32'd3,          32'd2,          7'd127, 7'd0,  1'b0};
      vecs[4]  = '{OP_BNE,  16'd4,    32'd1,          32'd2,          7'd0,   7'd4,  1'b1};
      vecs[5]  = '{OP_BGTE, 16'hFFCE, 32'hFFFFFFFB,   32'hFFFFFFFB,   7'd50,  7'd0,  1'b1};
      vecs[6]  = '{OP_BLTE, 16'd3,    32'd7,          32'hFFFFFFF9,   7'd50,  7'd51, 1'b0};
      vecs[7]  = '{OP_BLT,  16'hFFF0, 32'hFFFFFFF9,   32'd7,          7'd50,  7'd34, 1'b1};
      vecs[8]  = '{OP_J,    16'h0123, 32'd0,          32'd0,          7'd5,   7'd35, 1'b1};
      vecs[9]  = '{OP_JR,   16'd0,    32'h000000C5,   32'd0,          7'd5,   7'd69, 1'b1};
      vecs[10] = '{6'd63,   16'd7,    32'd1,          32'd1,          7'd127, 7'd0,  1'b0};
      vecs[11] = '{OP_BGT,  16'd2,    32'h7FFFFFFF,   32'h80000000,   7'd1,   7'd3,  1'b1};
      vecs[12] = '{OP_BGTE, 16'd9,    32'h80000000,   32'h7FFFFFFF,   7'd2,   7'd3,  1'b0};

      for (int i = 0; i < 13; i++) begin
         send(vecs[i].op, vecs[i].im, vecs[i].a, vecs[i].b, vecs[i].p);
         chk_res($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_tk, 7'd0, 1'b0);
      end

      // Call / return pair.
      send(OP_JAL, 16'd40, 32'd0, 32'd0, 7'd20); chk_res("call1", 7'd40, 1'b1, 7'd21, 1'b0);
      send(OP_JAL, 16'd60, 32'd0, 32'd0, 7'd41); chk_res("call2", 7'd60, 1'b1, 7'd42, 1'b0);
      send(OP_RET, 16'd0,  32'd0, 32'd0, 7'd60); chk_res("ret1",  7'd42, 1'b1, 7'd0,  1'b0);
      send(OP_RET, 16'd0,  32'd0, 32'd0, 7'd42); chk_res("ret2",  7'd21, 1'b1, 7'd0,  1'b0);

      // Overflow then underflow of the 4-entry stack.
      for (int i = 0; i < 5; i++) send(OP_JAL, 16'd0, 32'd0, 32'd0, 7'(i));
      for (int i = 0; i < 4; i++) begin
         send(OP_RET, 16'd0, 32'd0, 32'd0, 7'd0);
         chk_res($sformatf("ovf_ret%0d", i), 7'(5 - i), 1'b1, 7'd0, 1'b0);
      end
      send(OP_RET, 16'd0, 32'd9, 32'd0, 7'd0);
      chk_res("unf_ret", 7'd9, 1'b1, 7'd0, 1'b1);

      // Backpressure: held result, second jal waits and must not push early.
      idle();
      opcode = OP_JAL; imm = 16'd30; pc = 7'd10; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      opcode = OP_JAL; imm = 16'd50; pc = 7'd30;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_ready%0d", k), {31'd0, in_ready}, 32'd0);
         chk_res($sformatf("bp_hold%0d", k), 7'd30, 1'b1, 7'd11, 1'b0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1; #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_res("bp_second", 7'd50, 1'b1, 7'd31, 1'b0);
      send(OP_RET, 16'd0, 32'd0, 32'd0, 7'd0); chk_res("bp_ret1", 7'd31, 1'b1, 7'd0, 1'b0);
      send(OP_RET, 16'd0, 32'd0, 32'd0, 7'd0); chk_res("bp_ret2", 7'd11, 1'b1, 7'd0, 1'b0);
      send(OP_RET, 16'd0, 32'd9, 32'd0, 7'd0); chk_res("bp_ret3", 7'd9,  1'b1, 7'd0, 1'b1);

      // Flush during a held result drops both the result and the stack.
      send(OP_JAL, 16'd7, 32'd0, 32'd0, 7'd5);
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("fl_held", {31'd0, out_valid}, 32'd1);
      flush = 1'b1; in_valid = 1'b1; opcode = OP_RET; rs = 32'd3; out_ready = 1'b1; #1;
      chk("fl_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      send(OP_RET, 16'd0, 32'd12, 32'd0, 7'd0);
      chk_res("fl_ret", 7'd12, 1'b1, 7'd0, 1'b1);

      // Random requests against the reference model (stack empty on both sides here).
      for (int n = 0; n < 400; n++) begin
         r_op = ($urandom_range(0, 11) < 10) ? (6'd8 + 6'($urandom_range(0, 9))) : 6'($urandom);
         r_a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
         r_b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
         r_im = 16'($urandom);
         r_p  = 7'($urandom);
         model(r_op, r_im, r_a, r_b, r_p, e_pc, e_tk, e_lk, e_er);
         send(r_op, r_im, r_a, r_b, r_p);
         chk_res($sformatf("rnd%0d_op%0d", n, r_op), e_pc, e_tk, e_lk, e_er);
      end

      // Asynchronous reset mid-stream.
      send(OP_JAL, 16'd99, 32'd0, 32'd0, 7'd1);
      out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("ars_valid", {31'd0, out_valid}, 32'd0);
      chk("ars_pc",    {25'd0, next_pc},   32'd0);
      chk("ars_taken", {31'd0, taken},     32'd0);
      chk("ars_link",  {25'd0, link_pc},   32'd0);
      chk("ars_err",   {31'd0, ras_err},   32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ars_ready", {31'd0, in_ready}, 32'd1);
      send(OP_RET, 16'd0, 32'd44, 32'd0, 7'd0);
      chk_res("ars_ret", 7'd44, 1'b1, 7'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch/jump resolution unit for the single-issue processor: compares two register operands, resolves conditional branches, absolute jumps, jump-and-link, register jumps and returns, and produces a registered next PC with a taken flag. Holds a circular return-address stack (RAS) for call/return. It sits between register read and PC update, and uses a valid/ready handshake on both sides so the pipeline can stall it.

## Interface
- DATA_WIDTH, 32: operand width of rs/rt; signed compare.
- ADDRESS_WIDTH, 6: PC ports are ADDRESS_WIDTH+1 bits wide (bits [ADDRESS_WIDTH:0]).
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept this cycle.
- opcode  in  6  operation select.
- imm  in  16  branch offset (signed) or jump target.
- rs  in  DATA_WIDTH  first operand / jr target.
- rt  in  DATA_WIDTH  second operand.
- pc  in  ADDRESS_WIDTH+1  PC of the request.
- out_valid  out  1  result held in output register.
- out_ready  in  1  consumer takes result.
- next_pc  out  ADDRESS_WIDTH+1  resolved next PC.
- taken  out  1  control transfer taken.
- link_pc  out  ADDRESS_WIDTH+1  pc+1 for jal, else 0.
- ras_err  out  1  ret issued on empty RAS.

## Operation
- Let W = ADDRESS_WIDTH+1. All PC arithmetic is modulo 2^W. Offset = imm sign-extended, then truncated to W. Fall-through = pc+1.
- Conditional (taken → pc+offset, else pc+1, taken=condition): 001000 beq (rs==rt), 001001 bne (!=), 001010 bgt (>), 001011 bgte (>=), 001100 blt (<), 001101 blte (<=). All compares are signed, DATA_WIDTH bits.
- 001110 j: next_pc = imm[W-1:0], taken=1.
- 001111 jal: as j; link_pc = pc+1; push pc+1 onto RAS.
- 010000 jr: next_pc = rs[W-1:0], taken=1.
- 010001 ret: if RAS non-empty, next_pc = top entry, pop, taken=1, ras_err=0. If empty, next_pc = rs[W-1:0], taken=1, ras_err=1, no pop.
- Any other opcode: next_pc = pc+1, taken=0, no RAS effect.
- RAS: circular buffer with write pointer wp and count cnt (0..RAS_DEPTH). Push writes entry[wp], wp+1, and cnt saturates at RAS_DEPTH. When full, a push overwrites the oldest entry. Pop reads entry[wp-1], wp-1, cnt-1.
- Handshake: in_ready = !flush && (!out_valid || out_ready). A request is accepted on in_valid && in_ready. RAS updates occur only on acceptance.
- Output register: loaded on acceptance. out_valid clears on out_ready when no new acceptance occurs. Outputs stay stable while out_valid && !out_ready.
- Flush: clears out_valid, sets cnt=0 and wp=0, and accepts nothing that cycle.

## Timing
- Latency: 1 cycle. Acceptance at edge N means the result is visible after edge N (out_valid=1) until consumed.
- Throughput: 1 request per cycle when out_ready is held high.
- Back-to-back jal then ret: the ret in the next cycle sees the new top entry, because the RAS write takes effect at the accepting edge.
- Reset (async assert, any cycle including mid-transaction): out_valid=0, next_pc=0, taken=0, link_pc=0, ras_err=0, cnt=0, wp=0. RAS entry contents are don't-care. in_ready=1 after release unless flush is high.
- Flush and in_valid in the same cycle: the request is dropped. Flush and out_ready in the same cycle: the result is discarded.
- Simultaneous consume and accept: out_valid stays 1 and the new result replaces the old.

## Test plan
- beq taken: pc=10, imm=-3, rs=rt=5 → next_pc=7, taken=1, 1 cycle later. Then bgt with rs=-1, rt=1, pc=10 → next_pc=11, taken=0.
- Wrap: W=7, pc=126, beq taken with imm=5 → next_pc=3. blt not taken at pc=127 → next_pc=0.
- Call/return: jal pc=20 imm=40, jal pc=41 imm=60, ret, ret → next_pc 40, 60, 42, 21. link_pc values are 21 and 42. ras_err=0 throughout.
- RAS overflow/underflow with RAS_DEPTH=4: 5 jals pushing link values 1..5, then 5 rets → 5, 4, 3, 2, then a fifth ret with rs=9 gives next_pc=9 and ras_err=1.
- Backpressure: hold out_ready=0 after one accepted jal. in_ready must be 0 and outputs stable for 3 cycles. A second jal held on in_valid must not push. Release → second accepted the same cycle, and cnt ends at 2.
- Flush/reset: flush during a held result → out_valid=0 and a following ret gives ras_err=1. Assert rst_n low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
